// File: rtl/regfile_sync_read.sv
// Register file with one write port and two registered read ports.
// Latency: read data and ReadValid appear one cycle after the ReadEnable edge.
// Backpressure: none; ReadEnable may be held high to stream one result per cycle.
//
// Ports:
//   Clk, Reset_n                          clock, async active-low reset
//   RegWrite, WriteRegister, WriteData    write port
//   ReadEnable, ReadRegister1/2           read launch (samples both addresses)
//   ReadData1/2, ReadValid                registered read results
//
// Optional build macro REGFILE_ZERO_REG_EN: address 0 reads as zero and
// writes to it are dropped.
module regfile_sync_read #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [WIDTH-1:0]  WriteData,
  input  logic              ReadEnable,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [WIDTH-1:0]  ReadData1,
  output logic [WIDTH-1:0]  ReadData2,
  output logic              ReadValid
);

  localparam int DEPTH = 2 ** ADDR_W;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic [WIDTH-1:0] regs [DEPTH];
  logic             wr_en;
  logic [WIDTH-1:0] rd1_nxt;
  logic [WIDTH-1:0] rd2_nxt;

  // With the zero register enabled, writes to address 0 never happen, so
  // reg[0] stays at its reset value and is also excluded from forwarding.
  assign wr_en = RegWrite && !(ZERO_REG && (WriteRegister == '0));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[WriteRegister] <= WriteData;
    end
  end

  // Each port resolves its own forwarding; the forced-zero override wins last.
  always_comb begin
    rd1_nxt = regs[ReadRegister1];
    rd2_nxt = regs[ReadRegister2];
    if (BYPASS && wr_en && (WriteRegister == ReadRegister1)) begin
      rd1_nxt = WriteData;
    end
    if (BYPASS && wr_en && (WriteRegister == ReadRegister2)) begin
      rd2_nxt = WriteData;
    end
    if (ZERO_REG && (ReadRegister1 == '0)) begin
      rd1_nxt = '0;
    end
    if (ZERO_REG && (ReadRegister2 == '0)) begin
      rd2_nxt = '0;
    end
  end

  // Data holds when idle; only the valid flag drops.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ReadData1 <= '0;
      ReadData2 <= '0;
      ReadValid <= 1'b0;
    end else if (ReadEnable) begin
      ReadData1 <= rd1_nxt;
      ReadData2 <= rd2_nxt;
      ReadValid <= 1'b1;
    end else begin
      ReadValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_sync_read.sv
// Bench for regfile_sync_read: default build with and without forwarding,
// plus a narrow 8-bit / 8-entry instance, against a behavioural model.
module tb_regfile_sync_read;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instances (shared stimulus)
  logic        we = 0, re = 0;
  logic [4:0]  wa = 0, ra1 = 0, ra2 = 0;
  logic [31:0] wd = 0;
  logic [31:0] rd1, rd2, nb1, nb2;
  logic        rv, nbv;

  // 8-bit instance
  logic        we8 = 0, re8 = 0;
  logic [2:0]  wa8 = 0, ra8_1 = 0, ra8_2 = 0;
  logic [7:0]  wd8 = 0;
  logic [7:0]  r8_1, r8_2;
  logic        rv8;

  regfile_sync_read #(.WIDTH(32), .ADDR_W(5), .BYPASS(1'b1)) dut (
    .Clk(clk), .Reset_n(rst_n), .RegWrite(we), .WriteRegister(wa), .WriteData(wd),
    .ReadEnable(re), .ReadRegister1(ra1), .ReadRegister2(ra2),
    .ReadData1(rd1), .ReadData2(rd2), .ReadValid(rv));

  regfile_sync_read #(.WIDTH(32), .ADDR_W(5), .BYPASS(1'b0)) dut_nb (
    .Clk(clk), .Reset_n(rst_n), .RegWrite(we), .WriteRegister(wa), .WriteData(wd),
    .ReadEnable(re), .ReadRegister1(ra1), .ReadRegister2(ra2),
    .ReadData1(nb1), .ReadData2(nb2), .ReadValid(nbv));

  regfile_sync_read #(.WIDTH(8), .ADDR_W(3), .BYPASS(1'b1)) dut8 (
    .Clk(clk), .Reset_n(rst_n), .RegWrite(we8), .WriteRegister(wa8), .WriteData(wd8),
    .ReadEnable(re8), .ReadRegister1(ra8_1), .ReadRegister2(ra8_2),
    .ReadData1(r8_1), .ReadData2(r8_2), .ReadValid(rv8));

  int n_cmp = 0;
  int n_bad = 0;
  bit run = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [31:0] m32 [32];
  bit [7:0]  m8  [8];
  bit [31:0] e1, e2, en1, en2;
  bit        ev, ev8;
  bit [7:0]  e8_1, e8_2;

  function automatic bit [31:0] look32(input bit [4:0] a, input bit fwd);
    if (ZR && a == 0) return 32'h0;
    if (fwd && we && wa == a) return wd;
    return m32[a];
  endfunction

  function automatic bit [7:0] look8(input bit [2:0] a);
    if (ZR && a == 0) return 8'h0;
    if (we8 && wa8 == a) return wd8;
    return m8[a];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (m32[i]) m32[i] = 0;
      foreach (m8[i])  m8[i]  = 0;
      e1 = 0; e2 = 0; en1 = 0; en2 = 0; ev = 0;
      e8_1 = 0; e8_2 = 0; ev8 = 0;
    end else begin
      ev = re;
      if (re) begin
        e1  = look32(ra1, 1'b1);
        e2  = look32(ra2, 1'b1);
        en1 = look32(ra1, 1'b0);
        en2 = look32(ra2, 1'b0);
      end
      ev8 = re8;
      if (re8) begin
        e8_1 = look8(ra8_1);
        e8_2 = look8(ra8_2);
      end
      if (we && !(ZR && wa == 0)) m32[wa] = wd;
      if (we8 && !(ZR && wa8 == 0)) m8[wa8] = wd8;
    end
  end

  // Outputs are registered and held, so they are meaningful on every cycle.
  always @(negedge clk) begin
    if (run) begin
      chk("m_valid",    {31'b0, rv},   {31'b0, ev});
      chk("m_rd1",      rd1,           e1);
      chk("m_rd2",      rd2,           e2);
      chk("m_nb_valid", {31'b0, nbv},  {31'b0, ev});
      chk("m_nb_rd1",   nb1,           en1);
      chk("m_nb_rd2",   nb2,           en2);
      chk("m8_valid",   {31'b0, rv8},  {31'b0, ev8});
      chk("m8_rd1",     {24'b0, r8_1}, {24'b0, e8_1});
      chk("m8_rd2",     {24'b0, r8_2}, {24'b0, e8_2});
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic step;
    @(posedge clk);
    #2;
  endtask

  // Short reset pulse placed between two rising edges.
  task automatic reset_pulse;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", {31'b0, rv}, 32'h0);
    chk("rst_rd1",   rd1,         32'h0);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    @(posedge clk);
    #2;
    chk("reset_valid", {31'b0, rv}, 32'h0);
    chk("reset_rd1",   rd1,         32'h0);
    chk("reset_rd2",   rd2,         32'h0);
    run = 1;
    rst_n = 1'b1;

    // Reset clears storage
    we = 1; wa = 5; wd = 32'hDEADBEEF;
    step;
    we = 0;
    reset_pulse;
    re = 1; ra1 = 5; ra2 = 5;
    step;
    chk("rst_read5",  rd1,         32'h0);
    chk("rst_rvalid", {31'b0, rv}, 32'h1);
    re = 0;

    // Basic write / read and idle hold
    we = 1; wa = 3; wd = 32'h12345678;
    step;
    wa = 31; wd = 32'hCAFEF00D;
    step;
    we = 0; re = 1; ra1 = 3; ra2 = 31;
    step;
    chk("basic_rd1", rd1,         32'h12345678);
    chk("basic_rd2", rd2,         32'hCAFEF00D);
    chk("basic_vld", {31'b0, rv}, 32'h1);
    re = 0;
    step;
    chk("idle_vld",  {31'b0, rv}, 32'h0);
    chk("idle_rd1",  rd1,         32'h12345678);
    chk("idle_rd2",  rd2,         32'hCAFEF00D);

    // Same-edge forwarding
    we = 1; wa = 7; wd = 32'h11111111;
    step;
    wd = 32'h22222222; re = 1; ra1 = 7; ra2 = 7;
    step;
    chk("byp_rd1",   rd1, 32'h22222222);
    chk("byp_rd2",   rd2, 32'h22222222);
    chk("nobyp_rd1", nb1, 32'h11111111);
    chk("nobyp_rd2", nb2, 32'h11111111);
    we = 0;
    step;
    chk("after_byp",   rd1, 32'h22222222);
    chk("after_nobyp", nb2, 32'h22222222);
    re = 0;

    // Streaming reads
    we = 1;
    for (int i = 1; i <= 4; i++) begin
      wa = 5'(i); wd = 32'hA0 + 32'(i);
      step;
    end
    we = 0; re = 1;
    for (int i = 1; i <= 4; i++) begin
      ra1 = 5'(i); ra2 = 5'(5 - i);
      step;
      chk("stream_rd1", rd1,         32'hA0 + 32'(i));
      chk("stream_rd2", rd2,         32'hA5 - 32'(i));
      chk("stream_vld", {31'b0, rv}, 32'h1);
    end
    re = 0;

    // Address 0
    we = 1; wa = 0; wd = 32'hFFFFFFFF;
    step;
    we = 0; re = 1; ra1 = 0; ra2 = 0;
    step;
    chk("zero_rd1", rd1, ZR ? 32'h0 : 32'hFFFFFFFF);
    we = 1; wa = 0; wd = 32'h12345678;
    step;
    chk("zero_byp", rd2, ZR ? 32'h0 : 32'h12345678);
    we = 0; re = 0;

    // Narrow instance
    we8 = 1; wa8 = 7; wd8 = 8'h5A;
    step;
    we8 = 0; re8 = 1; ra8_1 = 7; ra8_2 = 7;
    step;
    chk("w8_rd7", {24'b0, r8_1}, 32'h5A);
    re8 = 0; we8 = 1;
    for (int i = 0; i < 8; i++) begin
      wa8 = 3'(i); wd8 = 8'(i);
      step;
    end
    we8 = 0; re8 = 1;
    for (int i = 0; i < 8; i++) begin
      ra8_1 = 3'(i); ra8_2 = 3'(7 - i);
      step;
      chk("w8_idx1", {24'b0, r8_1}, 32'(i));
      chk("w8_idx2", {24'b0, r8_2}, 32'(7 - i));
    end
    re8 = 0;

    // Random traffic, addresses biased low to provoke collisions
    for (int c = 0; c < 3000; c++) begin
      we  = ($urandom_range(0, 2) != 0);
      re  = ($urandom_range(0, 3) != 0);
      wa  = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      ra1 = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      ra2 = ($urandom_range(0, 1) == 1) ? ra1 : 5'($urandom);
      wd  = ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom);
      we8 = ($urandom_range(0, 1) == 1);
      re8 = ($urandom_range(0, 1) == 1);
      wa8 = 3'($urandom);
      ra8_1 = 3'($urandom);
      ra8_2 = 3'($urandom);
      wd8 = 8'($urandom);
      if ($urandom_range(0, 399) == 0) reset_pulse;
      step;
    end

    we = 0; re = 0; we8 = 0; re8 = 0;
    step;
    step;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_sync_read.md
Name: regfile_sync_read

Overview:
- Parametrised successor to the team's 32-input, 32-bit read-select mux.
- Combines register storage, write port and two registered read ports in one block.
- Intended as the pipelined register file for the CPU datapath.
- Reads have fixed 1-cycle latency, a valid flag and same-cycle write-to-read forwarding.

Parameters:
- WIDTH, 32, data bits per register.
- ADDR_W, 5, address bits; register count DEPTH = 2**ADDR_W (default 32).
- BYPASS, 1, 1 = a read sees a write to the same address on the same edge; 0 = read returns pre-write value.

Ports:
- Clk  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous, active-low reset.
- RegWrite  in  1  write enable.
- WriteRegister  in  ADDR_W  write address.
- WriteData  in  WIDTH  write data.
- ReadEnable  in  1  read request; samples both read addresses.
- ReadRegister1  in  ADDR_W  read address, port 1.
- ReadRegister2  in  ADDR_W  read address, port 2.
- ReadData1  out  WIDTH  registered read data, port 1.
- ReadData2  out  WIDTH  registered read data, port 2.
- ReadValid  out  1  high for the one cycle after each accepted ReadEnable.

Behaviour:
- Storage: DEPTH x WIDTH flops. No out-of-range addresses exist.
- Reset (Reset_n=0):
  - Asserts asynchronously.
  - Clears all registers, ReadData1, ReadData2 and ReadValid to 0.
  - Writes and reads are ignored while Reset_n is low.
  - After deassertion, the first rising edge is the first functional edge.
- Reset mid-operation: a pending read result is discarded and ReadValid goes 0 immediately.
- Write: on each rising edge with RegWrite=1, reg[WriteRegister] <= WriteData. Visible to reads launched on later edges.
- Read launch: on a rising edge with ReadEnable=1:
  - ReadDataN <= reg[ReadRegisterN].
  - ReadValid <= 1.
  - Latency is exactly 1 cycle (data and valid appear after that edge).
- Read idle: on a rising edge with ReadEnable=0, ReadData1/2 hold their last value and ReadValid <= 0.
- Back-to-back reads: ReadEnable held high gives a new result every cycle with ReadValid continuously 1. There is no backpressure.
- Simultaneous write and read, same address, same edge:
  - BYPASS=1: ReadDataN <= WriteData.
  - BYPASS=0: ReadDataN <= old register contents.
  - The register updates in both cases.
  - Each port is resolved independently; both ports may bypass on the same edge.
- Both read ports on the same address return identical data.
- Writes of 0 are ordinary writes.
- No read-modify-write and no multi-cycle paths.

Optional Feature:
Macro: REGFILE_ZERO_REG_EN
- Defined:
  - Address 0 is hard-wired zero and writes to address 0 are dropped.
  - Reads of address 0 always return 0, including when BYPASS=1 and address 0 is written on the same edge.
  - Synthesis may remove the reg[0] flops.
- Undefined: address 0 is an ordinary register, identical to all others.

Test Plan:
- Reset: write reg[5]=0xDEADBEEF; pulse Reset_n low between edges; read 5 -> ReadData1=0x00000000; ReadValid=0 during reset, 1 one cycle after the read edge.
- Basic write/read: write reg[3]=0x12345678 and reg[31]=0xCAFEF00D; then one edge with ReadEnable=1, RR1=3, RR2=31 -> next cycle ReadData1=0x12345678, ReadData2=0xCAFEF00D, ReadValid=1; after the following edge with ReadEnable=0 -> ReadValid=0, data held.
- Bypass: reg[7]=0x11111111; same edge RegWrite=1, WR=7, WD=0x22222222, ReadEnable=1, RR1=RR2=7 -> BYPASS=1 gives both ports 0x22222222; BYPASS=0 gives 0x11111111; next read of 7 gives 0x22222222 in both builds.
- Streaming: ReadEnable high 4 cycles on addresses 1,2,3,4 (preloaded 0xA1..0xA4) -> ReadValid high 4 consecutive cycles, data 0xA1,0xA2,0xA3,0xA4 in order.
- Zero register: write reg[0]=0xFFFFFFFF then read 0 -> 0x00000000 with REGFILE_ZERO_REG_EN; 0xFFFFFFFF without.
- Parametrisation: WIDTH=8, ADDR_W=3; write reg[7]=0x5A and read 7 -> 0x5A; write every address with its index and read back all 8 -> index values.
